// File: rtl/uart_rx_ctrl_if.sv
// Receive-byte handshake bundle between uart_rx_ctrl and its consumer.
// rx_data/rx_valid flow out of the receiver; rx_ready flows back.
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: sync, start detect, mid-bit sampling, stop check.
// Ports: clk, reset (async high), baud_tick (16x strobe), rx (raw line),
//   sipo_shift_en/sipo_bit (per-bit strobe), framing_err, overrun_err,
//   busy, rx_if.master (rx_data, rx_valid out; rx_ready in).
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             baud_tick,
    input  logic             rx,
    output logic             sipo_shift_en,
    output logic             sipo_bit,
    output logic             framing_err,
    output logic             overrun_err,
    output logic             busy,
    uart_rx_ctrl_if.master   rx_if
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t state, state_d;

    logic                  rx_meta, rx_s;
    logic                  armed;
    logic [TW-1:0]         tick_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] capture;

    logic tick_clr, tick_inc;
    logic bit_clr;
    logic arm_clr;
    logic data_smp;
    logic stop_ok, stop_bad;
    logic blocked;

    // A finished byte cannot land while the old one sits unconsumed.
    assign blocked = rx_if.rx_valid & ~rx_if.rx_ready;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        tick_clr = 1'b0;
        tick_inc = 1'b0;
        bit_clr  = 1'b0;
        arm_clr  = 1'b0;
        data_smp = 1'b0;
        stop_ok  = 1'b0;
        stop_bad = 1'b0;
        unique case (state)
            IDLE: begin
                // armed blocks a held-low line from retriggering
                if (baud_tick && armed && !rx_s) begin
                    state_d  = START;
                    tick_clr = 1'b1;
                    arm_clr  = 1'b1;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tick_cnt == TICK_MID) begin
                        if (!rx_s) begin
                            state_d  = DATA;
                            tick_clr = 1'b1;
                            bit_clr  = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        data_smp = 1'b1;
                        tick_clr = 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (tick_cnt == TICK_LAST) begin
                        stop_ok  = rx_s;
                        stop_bad = ~rx_s;
                        tick_clr = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta        <= 1'b1;
            rx_s           <= 1'b1;
            armed          <= 1'b0;
            tick_cnt       <= '0;
            bit_cnt        <= '0;
            capture        <= '0;
            sipo_shift_en  <= 1'b0;
            sipo_bit       <= 1'b0;
            framing_err    <= 1'b0;
            overrun_err    <= 1'b0;
            rx_if.rx_data  <= '0;
            rx_if.rx_valid <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;

            if (arm_clr) begin
                armed <= 1'b0;
            end else if (state == IDLE && rx_s) begin
                armed <= 1'b1;
            end

            if (tick_clr) begin
                tick_cnt <= '0;
            end else if (tick_inc) begin
                tick_cnt <= tick_cnt + TW'(1);
            end

            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (data_smp) begin
                bit_cnt <= bit_cnt + BW'(1);
            end

            sipo_shift_en <= data_smp;
            if (data_smp) begin
                sipo_bit <= rx_s;
                // first line bit ends up in bit0 after the last shift
                capture  <= {rx_s, capture[DATA_WIDTH-1:1]};
            end

            framing_err <= stop_bad;
            overrun_err <= stop_ok & blocked;

            if (stop_ok && !blocked) begin
                rx_if.rx_data  <= capture;
                rx_if.rx_valid <= 1'b1;
            end else if (rx_if.rx_valid && rx_if.rx_ready) begin
                rx_if.rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames driven on rx, bytes and
// per-bit strobes checked against queues filled by the stimulus.
module tb_uart_rx_ctrl;
    localparam int OS   = 16;
    localparam int TDIV = 4;
    localparam int BIT  = OS * TDIV;

    logic clk = 1'b0;
    logic reset;
    logic baud_tick = 1'b0;
    logic rx;
    logic sipo_shift_en, sipo_bit;
    logic framing_err, overrun_err, busy;

    uart_rx_ctrl_if #(.DATA_WIDTH(8)) rx_if ();

    uart_rx_ctrl #(
        .DATA_WIDTH(8),
        .OVERSAMPLE(OS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .baud_tick    (baud_tick),
        .rx           (rx),
        .sipo_shift_en(sipo_shift_en),
        .sipo_bit     (sipo_bit),
        .framing_err  (framing_err),
        .overrun_err  (overrun_err),
        .busy         (busy),
        .rx_if        (rx_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int sipo_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vcyc = 0;
    logic prev_tick = 1'b0;
    logic prev_valid = 1'b0;

    logic [7:0] sb[$];
    logic       exp_bits[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        forever begin
            repeat (TDIV - 1) begin
                @(posedge clk);
                #1;
                baud_tick = 1'b0;
            end
            @(posedge clk);
            #1;
            baud_tick = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (sipo_shift_en) begin
                sipo_cnt++;
                chk("sipo_lat", prev_tick, 1);
                chk("sipo_q", exp_bits.size() != 0, 1);
                if (exp_bits.size() != 0) begin
                    chk("sipo_bit", sipo_bit, exp_bits.pop_front());
                end
            end
            if (rx_if.rx_valid && !prev_valid) begin
                chk("valid_lat", prev_tick, 1);
            end
            if (rx_if.rx_valid) vcyc++;
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                chk("sb_q", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    chk("rx_data", rx_if.rx_data, sb.pop_front());
                end
            end
            if (framing_err) fe_cnt++;
            if (overrun_err) ov_cnt++;
        end
        prev_tick  = baud_tick;
        prev_valid = rx_if.rx_valid;
    end

    // abort_bit >= 0 resets the DUT partway through that data bit
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input int abort_bit);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == abort_bit) begin
                wait_clk(10);
                reset = 1'b1;
                #1;
                chk("rst_mid", {sipo_shift_en, framing_err, overrun_err,
                                rx_if.rx_valid, busy, rx_if.rx_data}, 0);
                rx = 1'b1;
                wait_clk(2);
                reset = 1'b0;
                exp_bits.delete();
                wait_clk(BIT);
                return;
            end
            wait_clk(BIT);
        end
        rx = stop;
        wait_clk(BIT);
    endtask

    task automatic pulse_ready();
        rx_if.rx_ready = 1'b1;
        wait_clk(1);
        rx_if.rx_ready = 1'b0;
        wait_clk(2);
    endtask

    int s0, f0, o0, v0;

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        rx_if.rx_ready = 1'b0;
        wait_clk(3);
        chk("reset_state", {sipo_shift_en, sipo_bit, framing_err,
                            overrun_err, rx_if.rx_valid, busy,
                            rx_if.rx_data}, 0);
        reset = 1'b0;
        wait_clk(BIT);

        // 1: single frame, not consumed
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1);
        wait_clk(4);
        chk("t1_strobes", sipo_cnt, 8);
        chk("t1_valid", rx_if.rx_valid, 1);
        chk("t1_data", rx_if.rx_data, 8'hA5);
        chk("t1_errs", fe_cnt + ov_cnt, 0);
        chk("t1_busy", busy, 0);
        pulse_ready();
        chk("t1_consumed", rx_if.rx_valid, 0);

        // 2: false start
        s0 = sipo_cnt;
        rx = 1'b0;
        wait_clk(12);
        chk("t2_busy_hi", busy, 1);
        wait_clk(4 * TDIV - 12);
        rx = 1'b1;
        wait_clk(2 * BIT);
        chk("t2_strobes", sipo_cnt - s0, 0);
        chk("t2_busy_lo", busy, 0);
        chk("t2_valid", rx_if.rx_valid, 0);

        // 3: framing error, then held-low line
        s0 = sipo_cnt;
        f0 = fe_cnt;
        send_frame(8'h3C, 1'b0, -1);
        wait_clk(3 * BIT);
        chk("t3_fe", fe_cnt - f0, 1);
        chk("t3_valid", rx_if.rx_valid, 0);
        chk("t3_busy_low", busy, 0);
        chk("t3_strobes", sipo_cnt - s0, 8);
        rx = 1'b1;
        wait_clk(2 * BIT);
        chk("t3_no_retrig", sipo_cnt - s0, 8);
        chk("t3_ov", ov_cnt, 0);

        // 4: overrun
        o0 = ov_cnt;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        wait_clk(4);
        chk("t4_ov", ov_cnt - o0, 1);
        chk("t4_data", rx_if.rx_data, 8'h11);
        chk("t4_valid", rx_if.rx_valid, 1);
        pulse_ready();
        chk("t4_consumed", rx_if.rx_valid, 0);

        // 5: streaming with ready held
        o0 = ov_cnt;
        v0 = vcyc;
        rx_if.rx_ready = 1'b1;
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1, -1);
        sb.push_back(8'hFF);
        send_frame(8'hFF, 1'b1, -1);
        sb.push_back(8'h00);
        send_frame(8'h00, 1'b1, -1);
        wait_clk(4);
        rx_if.rx_ready = 1'b0;
        chk("t5_vcyc", vcyc - v0, 3);
        chk("t5_ov", ov_cnt - o0, 0);
        chk("t5_valid", rx_if.rx_valid, 0);

        // 6: reset mid-frame, then clean frame
        send_frame(8'h81, 1'b1, 4);
        s0 = sipo_cnt;
        sb.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1);
        wait_clk(4);
        chk("t6_strobes", sipo_cnt - s0, 8);
        chk("t6_valid", rx_if.rx_valid, 1);
        pulse_ready();
        chk("t6_consumed", rx_if.rx_valid, 0);

        chk("sb_empty", sb.size(), 0);
        chk("bits_empty", exp_bits.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
